// File: rtl/branch_train_queue.sv
// branch_train_queue
//   In-order tracker that sits between the gshare predict port and its train port.
//   Every issued prediction {pc, taken, history} is queued. When the oldest branch
//   resolves, its entry is popped and a single registered train pulse is sent.
//   A misprediction empties the queue (younger entries are wrong-path) and
//   raises flush together with the train pulse.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   pred_valid/pc/taken/history prediction capture; pred_ready = not full
//   resolve_valid/taken         head resolution; resolve_ready = not empty
//   train_*                     registered train pulse; fields hold between pulses
//   flush                       pulses with a mispredicted train
//   count                       occupancy
//   overflow/underflow          sticky error flags, cleared by reset only

// One storage slot. Entries carry no reset: occupancy alone decides validity.
module btq_entry #(
  parameter int ENT_W = 15
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ENT_W-1:0] d,
  output logic [ENT_W-1:0] q
);
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module branch_train_queue #(
  parameter int PC_W   = 7,
  parameter int HIST_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [HIST_W-1:0]        pred_history,
  output logic                     pred_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     resolve_ready,
  output logic                     train_valid,
  output logic [PC_W-1:0]          train_pc,
  output logic                     train_taken,
  output logic                     train_mispredicted,
  output logic [HIST_W-1:0]        train_history,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              taken;
    logic [HIST_W-1:0] hist;
  } ent_t;

  localparam int ENT_W = $bits(ent_t);

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt;
  ent_t [DEPTH-1:0] ent_q;
  ent_t           wr_ent, head;
  logic           pop, mispred, push_acc;

  // Ready flags come only from the registered count, so a pop this cycle
  // never makes room for a push in the same cycle.
  assign pred_ready    = (cnt != CW'(DEPTH));
  assign resolve_ready = (cnt != '0);
  assign count         = cnt;

  assign head    = ent_q[rd_ptr];
  assign pop     = resolve_valid && resolve_ready;
  assign mispred = pop && (resolve_taken ^ head.taken);
  // A push alongside a misprediction is wrong-path and is simply dropped.
  assign push_acc = pred_valid && pred_ready && !mispred;

  assign wr_ent = '{pc: pred_pc, taken: pred_taken, hist: pred_history};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    btq_entry #(.ENT_W(ENT_W)) u_ent (
      .clk (clk),
      .we  (push_acc && (wr_ptr == AW'(i))),
      .d   (wr_ent),
      .q   (ent_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      cnt                <= '0;
      train_valid        <= 1'b0;
      train_pc           <= '0;
      train_taken        <= 1'b0;
      train_mispredicted <= 1'b0;
      train_history      <= '0;
      flush              <= 1'b0;
      overflow           <= 1'b0;
      underflow          <= 1'b0;
    end else begin
      train_valid <= pop;
      flush       <= mispred;
      if (pop) begin
        train_pc           <= head.pc;
        train_history      <= head.hist;
        train_taken        <= resolve_taken;
        train_mispredicted <= mispred;
      end
      if (pred_valid && !pred_ready && !mispred) overflow  <= 1'b1;
      if (resolve_valid && !resolve_ready)       underflow <= 1'b1;
      if (mispred) begin
        // Discard everything still in flight; the write side did not move.
        rd_ptr <= wr_ptr;
        cnt    <= '0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + AW'(1);
        if (pop)      rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + CW'(push_acc) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_branch_train_queue.sv
module tb_branch_train_queue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid, pred_taken, pred_ready;
  logic [6:0] pred_pc, pred_history;
  logic       resolve_valid, resolve_taken, resolve_ready;
  logic       train_valid, train_taken, train_mispredicted, flush;
  logic [6:0] train_pc, train_history;
  logic [2:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  branch_train_queue #(.PC_W(7), .HIST_W(7), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_history(pred_history), .pred_ready(pred_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_ready(resolve_ready),
    .train_valid(train_valid), .train_pc(train_pc), .train_taken(train_taken),
    .train_mispredicted(train_mispredicted), .train_history(train_history),
    .flush(flush), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_history = 0;
    resolve_valid = 0; resolve_taken = 0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; step(); rst_n = 1;
  endtask

  task automatic push(input logic [6:0] pc, input logic t, input logic [6:0] h);
    pred_valid = 1; pred_pc = pc; pred_taken = t; pred_history = h;
    step();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pred_ready: got %b exp 1", pred_ready); end
    n_checks++; if (resolve_ready !== 1'b0) begin n_fail++; $display("FAIL rst_resolve_ready: got %b exp 0", resolve_ready); end
    n_checks++; if ({train_valid, train_taken, train_mispredicted, flush} !== 4'b0) begin n_fail++; $display("FAIL rst_train_bits: got %b exp 0000", {train_valid, train_taken, train_mispredicted, flush}); end
    n_checks++; if ({train_pc, train_history} !== 14'd0) begin n_fail++; $display("FAIL rst_train_fields: got %h exp 0", {train_pc, train_history}); end
    n_checks++; if ({count, overflow, underflow} !== 5'd0) begin n_fail++; $display("FAIL rst_count_flags: got %b exp 00000", {count, overflow, underflow}); end
  endtask

  task automatic test_single_mispredict();
    push(7'd10, 1'b0, 7'd0);
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL t1_count_push: got %0d exp 1", count); end
    resolve_valid = 1; resolve_taken = 1; step(); idle();
    n_checks++; if ({train_valid, train_taken, train_mispredicted, flush} !== 4'b1111) begin n_fail++; $display("FAIL t1_pulse: got %b exp 1111", {train_valid, train_taken, train_mispredicted, flush}); end
    n_checks++; if (train_pc !== 7'd10 || train_history !== 7'd0) begin n_fail++; $display("FAIL t1_fields: got pc %0d hist %0d exp pc 10 hist 0", train_pc, train_history); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL t1_count: got %0d exp 0", count); end
    step();
    n_checks++; if (train_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL t1_one_shot: got tv %b fl %b exp 0 0", train_valid, flush); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] pcs [3] = '{7'd10, 7'd20, 7'd14};
    logic [6:0] hs  [3] = '{7'd1, 7'd2, 7'd4};
    logic       ts  [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) push(pcs[i], ts[i], hs[i]);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL t2_count_full3: got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      resolve_valid = 1; resolve_taken = ts[i]; step();
      n_checks++;
      if (train_valid !== 1'b1 || train_pc !== pcs[i] || train_history !== hs[i] ||
          train_taken !== ts[i] || train_mispredicted !== 1'b0 || flush !== 1'b0 ||
          count !== 3'(2 - i)) begin
        n_fail++;
        $display("FAIL t2_pulse%0d: got v%b pc%0d h%0d t%b m%b f%b c%0d exp v1 pc%0d h%0d t%b m0 f0 c%0d",
                 i, train_valid, train_pc, train_history, train_taken, train_mispredicted, flush, count,
                 pcs[i], hs[i], ts[i], 2 - i);
      end
    end
    idle(); step();
    n_checks++; if (train_valid !== 1'b0 || train_pc !== 7'd14 || train_history !== 7'd4) begin n_fail++; $display("FAIL t2_hold: got v%b pc%0d h%0d exp v0 pc14 h4", train_valid, train_pc, train_history); end
  endtask

  task automatic test_overflow();
    logic [6:0] exp_pc [4] = '{7'd2, 7'd3, 7'd4, 7'd6};
    do_reset();
    for (int i = 1; i <= 4; i++) push(7'(i), 1'b0, 7'(i));
    n_checks++; if (pred_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL t3_full: got rdy %b cnt %0d exp 0 4", pred_ready, count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL t3_no_ovf_yet: got %b exp 0", overflow); end
    push(7'd5, 1'b0, 7'd5);
    n_checks++; if (overflow !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL t3_ovf: got ovf %b cnt %0d exp 1 4", overflow, count); end
    // Resolve while full with a push in the same cycle: the push is refused.
    pred_valid = 1; pred_pc = 7'd9; resolve_valid = 1; resolve_taken = 0; step(); idle();
    n_checks++; if (count !== 3'd3 || train_pc !== 7'd1 || train_valid !== 1'b1 || pred_ready !== 1'b1) begin n_fail++; $display("FAIL t3_pop_full: got cnt %0d pc %0d v %b rdy %b exp 3 1 1 1", count, train_pc, train_valid, pred_ready); end
    push(7'd6, 1'b0, 7'd6);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL t3_push_after: got %0d exp 4", count); end
    for (int i = 0; i < 4; i++) begin
      resolve_valid = 1; resolve_taken = 0; step();
      n_checks++; if (train_valid !== 1'b1 || train_pc !== exp_pc[i]) begin n_fail++; $display("FAIL t3_drain%0d: got v%b pc %0d exp v1 pc %0d", i, train_valid, train_pc, exp_pc[i]); end
    end
    idle();
  endtask

  task automatic test_flush_with_push();
    do_reset();
    push(7'd7, 1'b0, 7'd3);
    push(7'd8, 1'b1, 7'd5);
    push(7'd9, 1'b1, 7'd6);
    pred_valid = 1; pred_pc = 7'd11; pred_taken = 1;
    resolve_valid = 1; resolve_taken = 1; step(); idle();
    n_checks++; if (train_valid !== 1'b1 || train_mispredicted !== 1'b1 || flush !== 1'b1 || train_pc !== 7'd7 || train_history !== 7'd3) begin n_fail++; $display("FAIL t4_pulse: got v%b m%b f%b pc%0d h%0d exp v1 m1 f1 pc7 h3", train_valid, train_mispredicted, flush, train_pc, train_history); end
    n_checks++; if (count !== 3'd0 || resolve_ready !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL t4_state: got cnt %0d rr %b ovf %b exp 0 0 0", count, resolve_ready, overflow); end
    push(7'd12, 1'b0, 7'd1);
    resolve_valid = 1; resolve_taken = 0; step(); idle();
    n_checks++; if (train_valid !== 1'b1 || train_pc !== 7'd12 || flush !== 1'b0) begin n_fail++; $display("FAIL t4_after: got v%b pc %0d f%b exp v1 pc 12 f0", train_valid, train_pc, flush); end
  endtask

  task automatic test_underflow();
    resolve_valid = 1; resolve_taken = 1; step(); idle();
    n_checks++; if (train_valid !== 1'b0 || underflow !== 1'b1 || count !== 3'd0 || train_pc !== 7'd12) begin n_fail++; $display("FAIL t5_unf: got v%b unf%b cnt%0d pc%0d exp v0 unf1 cnt0 pc12", train_valid, underflow, count, train_pc); end
    // Push with a resolve while empty: push taken, resolve ignored.
    pred_valid = 1; pred_pc = 7'd13; pred_taken = 1; pred_history = 7'd9;
    resolve_valid = 1; resolve_taken = 0; step(); idle();
    n_checks++; if (count !== 3'd1 || train_valid !== 1'b0) begin n_fail++; $display("FAIL t5_push_empty: got cnt%0d v%b exp 1 0", count, train_valid); end
    resolve_valid = 1; resolve_taken = 1; step(); idle();
    n_checks++; if (train_valid !== 1'b1 || train_pc !== 7'd13 || train_history !== 7'd9 || train_mispredicted !== 1'b0) begin n_fail++; $display("FAIL t5_ptrs: got v%b pc%0d h%0d m%b exp v1 pc13 h9 m0", train_valid, train_pc, train_history, train_mispredicted); end
  endtask

  task automatic test_mid_reset();
    push(7'd1, 1'b0, 7'd1);
    push(7'd2, 1'b0, 7'd2);
    push(7'd3, 1'b0, 7'd3);
    n_checks++; if (count !== 3'd3 || underflow !== 1'b1) begin n_fail++; $display("FAIL t6_pre: got cnt%0d unf%b exp 3 1", count, underflow); end
    rst_n = 0; resolve_valid = 1; resolve_taken = 0; step(); idle(); rst_n = 1;
    n_checks++; if (count !== 3'd0 || resolve_ready !== 1'b0 || train_valid !== 1'b0) begin n_fail++; $display("FAIL t6_rst: got cnt%0d rr%b v%b exp 0 0 0", count, resolve_ready, train_valid); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || train_pc !== 7'd0) begin n_fail++; $display("FAIL t6_flags: got ovf%b unf%b pc%0d exp 0 0 0", overflow, underflow, train_pc); end
    step();
    n_checks++; if (train_valid !== 1'b0 || pred_ready !== 1'b1) begin n_fail++; $display("FAIL t6_post: got v%b rdy%b exp 0 1", train_valid, pred_ready); end
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_single_mispredict();
    test_back_to_back();
    test_overflow();
    test_flush_with_push();
    test_underflow();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
